apb2axi: RTL

- APB3/APB4 slave to AXI4-Lite master bridge; the reverse of the AXI-to-APB bridge.
- Lets an APB-side agent (debug port, peripheral-bus DMA) reach the AXI fabric.
- Each APB access becomes exactly one AXI4-Lite single-beat transaction, 32-bit data.
- pready is held low until the AXI response returns.

---
 rtl/apb2axi_if.sv | 63 ++++++
 rtl/apb2axi.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/apb2axi_if.sv
// Bus bundles for the APB-to-AXI4-Lite bridge.
// apb2axi_apb_if : APB3/APB4 bus; the bridge sits on the slave modport.
// apb2axi_axi_if : AXI4-Lite bus (32-bit data); the bridge sits on the master modport.
//
// Handshake rule (both buses): a beat moves on a rising clock edge where
// valid and ready are both high. Once raised, valid stays high until that
// edge, and the payload does not change while valid is high. Ready may
// depend on valid. APB completes an access on the edge where psel, penable
// and pready are all high.

interface apb2axi_apb_if #(
  parameter int ADRW = 16
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [ADRW-1:0] paddr;
  logic [31:0]     pwdata;
  logic [3:0]      pstrb;
  logic [31:0]     prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

interface apb2axi_axi_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/apb2axi.sv
// APB slave to AXI4-Lite master bridge. Every APB access becomes one
// single-beat AXI4-Lite transaction; pready stays low until the AXI
// response has come back. paddr is placed in a window at AXI_BASE.
// All AXI outputs are decoded from registered state only, so no AXI ready
// reaches an AXI valid combinationally.

module apb2axi #(
  parameter int          APB_ADRW = 16,
  parameter logic [31:0] AXI_BASE = 32'h8000_0000
) (
  input  logic          aclk,
  input  logic          areset,
  apb2axi_apb_if.slave  apb,
  apb2axi_axi_if.master axi,
  output logic [5:0]    state_dbg
);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    WREQ = 6'b000010,
    WRSP = 6'b000100,
    RREQ = 6'b001000,
    RRSP = 6'b010000,
    DONE = 6'b100000
  } state_t;

  state_t                state, state_nxt;
  logic [APB_ADRW-1:0]   addr_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            strb_reg;
  logic [31:0]           prdata_reg;
  logic                  err;
  logic                  aw_done;
  logic                  w_done;

  logic setup;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic unused_resp_bits;

  assign setup  = apb.psel & ~apb.penable;
  assign aw_hs  = axi.awvalid & axi.awready;
  assign w_hs   = axi.wvalid & axi.wready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  // Only the error bit of each response is meaningful to APB.
  assign unused_resp_bits = axi.bresp[0] ^ axi.rresp[0];

  assign axi.awaddr = {AXI_BASE[31:APB_ADRW], addr_reg};
  assign axi.araddr = {AXI_BASE[31:APB_ADRW], addr_reg};
  assign axi.wdata  = wdata_reg;
  assign axi.wstrb  = strb_reg;
  assign apb.prdata = prdata_reg;
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup) state_nxt = apb.pwrite ? WREQ : RREQ;
      end
      WREQ: begin
        axi.awvalid = ~aw_done;
        axi.wvalid  = ~w_done;
        if (aw_fin && w_fin) state_nxt = WRSP;
      end
      WRSP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_nxt = DONE;
      end
      RREQ: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nxt = RRSP;
      end
      RRSP: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_nxt = DONE;
      end
      DONE: begin
        apb.pready  = 1'b1;
        apb.pslverr = err;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the APB request in the setup phase; reads use a full strobe.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
    end else if (state == IDLE && setup) begin
      addr_reg  <= apb.paddr;
      wdata_reg <= apb.pwdata;
      strb_reg  <= apb.pwrite ? apb.pstrb : 4'hF;
    end
  end

  // Track which of the two write-request channels has already handshaken.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WREQ && !(aw_fin && w_fin)) begin
      aw_done <= aw_fin;
      w_done  <= w_fin;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

  // Capture response status and read data when the AXI response arrives.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err        <= 1'b0;
      prdata_reg <= '0;
    end else if (state == WRSP && axi.bvalid) begin
      err <= axi.bresp[1];
    end else if (state == RRSP && axi.rvalid) begin
      err        <= axi.rresp[1];
      prdata_reg <= axi.rdata;
    end
  end

endmodule
